spi_ram_ctrl: RTL and testbench

- Command decoder and sequencer between the SPI slave serial front-end and a single-port synchronous RAM.
- Takes 10-bit command words {cmd[1:0], payload[7:0]} from the slave, holds the write and read address registers, and issues RAM write/read strobes.
- Returns read data to the slave through the tx_data/tx_valid pair.
- Sits one level above the SPI slave in the SPI-to-memory subsystem.

---
 rtl/spi_ram_pkg.sv | 30 +++
 rtl/spi_ram_lat_cnt.sv | 37 +++
 rtl/spi_ram_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_spi_ram_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// Shared command codes, FSM state encoding and field helpers for the SPI-to-RAM controller.
package spi_ram_pkg;

    localparam int unsigned CMD_WIDTH     = 10;
    localparam int unsigned PAYLOAD_WIDTH = 8;

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RD_DONE  = 3'd4
    } state_e;

    function automatic cmd_e cmd_of(input logic [CMD_WIDTH-1:0] word);
        return cmd_e'(word[CMD_WIDTH-1 -: 2]);
    endfunction

    function automatic logic [PAYLOAD_WIDTH-1:0] payload_of(input logic [CMD_WIDTH-1:0] word);
        return word[PAYLOAD_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/spi_ram_lat_cnt.sv
// RAM read-latency down-counter: loaded in RD_ISSUE, counts the RD_WAIT cycles.
module spi_ram_lat_cnt #(
    parameter int unsigned LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam logic [1:0] LOAD_VAL = 2'(LAT - 1);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the last wait cycle so the FSM moves to RD_DONE on that edge.
    assign done_o = (cnt_q <= 2'd1);

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder/sequencer between the SPI slave and a single-port synchronous RAM.
// Optional: define SPI_RAM_AUTO_INC_EN for post-access address auto-increment.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RAM_RD_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic [CMD_WIDTH-1:0]  rx_data,
    input  logic                  rx_valid,
    input  logic                  ss_n,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  cmd_err
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    wr_vld_q, wr_vld_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    rx_valid_q;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;
    logic                    cmd_err_q, cmd_err_d;
    logic                    discard_q, discard_d;

    logic                    accept;
    cmd_e                    cmd;
    logic [PAYLOAD_WIDTH-1:0] payload;
    logic                    lat_load;
    logic                    lat_en;
    logic                    lat_done;

    assign accept  = rx_valid && !rx_valid_q;
    assign cmd     = cmd_of(rx_data);
    assign payload = payload_of(rx_data);

    spi_ram_lat_cnt #(
        .LAT (RAM_RD_LAT)
    ) u_lat_cnt (
        .clk_i  (CLK),
        .rst_i  (rst),
        .load_i (lat_load),
        .en_i   (lat_en),
        .done_o (lat_done)
    );

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        wr_vld_d    = wr_vld_q;
        rd_vld_d    = rd_vld_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        cmd_err_d   = cmd_err_q;
        discard_d   = discard_q;
        lat_load    = 1'b0;
        lat_en      = 1'b0;

        // Deselect while the read is still in flight poisons its result.
        if (ss_n && (state_q == RD_ISSUE || state_q == RD_WAIT)) begin
            discard_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    tx_valid_d = 1'b0;
                    case (cmd)
                        CMD_WR_ADDR: begin
                            wr_addr_d = payload[ADDR_WIDTH-1:0];
                            wr_vld_d  = 1'b1;
                        end
                        CMD_WR_DATA: begin
                            if (wr_vld_q) begin
                                ram_wdata_d = DATA_WIDTH'(payload);
                                ram_addr_d  = wr_addr_q;
                                state_d     = WR;
                            end else begin
                                cmd_err_d = 1'b1;
                            end
                        end
                        CMD_RD_ADDR: begin
                            rd_addr_d = payload[ADDR_WIDTH-1:0];
                            rd_vld_d  = 1'b1;
                        end
                        CMD_RD_DATA: begin
                            if (rd_vld_q) begin
                                ram_addr_d = rd_addr_q;
                                discard_d  = 1'b0;
                                state_d    = RD_ISSUE;
                            end else begin
                                cmd_err_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            WR: begin
                state_d = IDLE;
`ifdef SPI_RAM_AUTO_INC_EN
                wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
`endif
            end
            RD_ISSUE: begin
                lat_load = 1'b1;
                state_d  = (RAM_RD_LAT > 1) ? RD_WAIT : RD_DONE;
`ifdef SPI_RAM_AUTO_INC_EN
                rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
`endif
            end
            RD_WAIT: begin
                lat_en = 1'b1;
                if (lat_done) begin
                    state_d = RD_DONE;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
                if (!discard_q && !ss_n) begin
                    tx_data_d  = ram_rdata;
                    tx_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept && (state_q != IDLE)) begin
            cmd_err_d = 1'b1;
        end

        if (ss_n) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            wr_vld_q    <= 1'b0;
            rd_vld_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cmd_err_q   <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            wr_vld_q    <= wr_vld_d;
            rd_vld_q    <= rd_vld_d;
            rx_valid_q  <= rx_valid;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cmd_err_q   <= cmd_err_d;
            discard_q   <= discard_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = (state_q == WR);
    assign ram_re    = (state_q == RD_ISSUE);
    assign busy      = (state_q != IDLE);
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Bench for spi_ram_ctrl: three instances (RAM_RD_LAT 1..3) share stimulus, checked against a transaction model.
module tb_spi_ram_ctrl;

    localparam int NOBS = 6;

    logic       CLK;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       ss_n;

    logic [7:0] tx_data_w   [3];
    logic [7:0] ram_addr_w  [3];
    logic [7:0] ram_wdata_w [3];
    logic [2:0] tx_valid_w, ram_we_w, ram_re_w, busy_w, cmd_err_w;

    int n_checks = 0;
    int n_errors = 0;

    // transaction-level reference state
    logic [7:0] wa_m, ra_m, addr_m, wd_m;
    logic [7:0] mem_m [256];
    logic [7:0] td_m [3];
    bit         tv_m [3];
    bit         wv_m, rv_m, err_m;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : lane
        logic [7:0] mem  [256];
        logic [7:0] pipe [3];

        spi_ram_ctrl #(
            .ADDR_WIDTH (8),
            .DATA_WIDTH (8),
            .RAM_RD_LAT (g + 1)
        ) u_dut (
            .CLK       (CLK),
            .rst       (rst),
            .rx_data   (rx_data),
            .rx_valid  (rx_valid),
            .ss_n      (ss_n),
            .tx_data   (tx_data_w[g]),
            .tx_valid  (tx_valid_w[g]),
            .ram_addr  (ram_addr_w[g]),
            .ram_wdata (ram_wdata_w[g]),
            .ram_we    (ram_we_w[g]),
            .ram_re    (ram_re_w[g]),
            .ram_rdata (pipe[g]),
            .busy      (busy_w[g]),
            .cmd_err   (cmd_err_w[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        end

        // Synchronous RAM: data for an address sampled at edge E appears after edge E+LAT-1.
        always @(posedge CLK) begin
            if (ram_we_w[g]) mem[ram_addr_w[g]] <= ram_wdata_w[g];
            pipe[0] <= mem[ram_addr_w[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        wa_m = '0; ra_m = '0; addr_m = '0; wd_m = '0;
        wv_m = 0; rv_m = 0; err_m = 0;
        for (int g = 0; g < 3; g++) begin
            tv_m[g] = 0;
            td_m[g] = '0;
        end
    endtask

    task automatic check_reset(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s L%0d tx_data", tag, g + 1), tx_data_w[g], 0);
            check($sformatf("%s L%0d tx_valid", tag, g + 1), tx_valid_w[g], 0);
            check($sformatf("%s L%0d ram_addr", tag, g + 1), ram_addr_w[g], 0);
            check($sformatf("%s L%0d ram_wdata", tag, g + 1), ram_wdata_w[g], 0);
            check($sformatf("%s L%0d ram_we", tag, g + 1), ram_we_w[g], 0);
            check($sformatf("%s L%0d ram_re", tag, g + 1), ram_re_w[g], 0);
            check($sformatf("%s L%0d busy", tag, g + 1), busy_w[g], 0);
            check($sformatf("%s L%0d cmd_err", tag, g + 1), cmd_err_w[g], 0);
        end
    endtask

    // Sends one command word; ssp>0 pulses ss_n high so that edge N+ssp sees it,
    // has_extra injects a second rising rx_valid that lands at edge N+2 (while busy).
    task automatic issue(input logic [9:0] w, input int hold, input int ssp,
                         input logic [9:0] extra, input bit has_extra);
        logic [1:0] c;
        logic [7:0] pl;
        logic [7:0] rd_exp;
        bit         we_ok, re_ok, exp_tv;
        int         lat;

        c      = w[9:8];
        pl     = w[7:0];
        rd_exp = '0;
        we_ok  = (c == 2'b01) && wv_m;
        re_ok  = (c == 2'b11) && rv_m;
        if ((c == 2'b01 && !wv_m) || (c == 2'b11 && !rv_m)) err_m = 1;
        case (c)
            2'b00: begin wa_m = pl; wv_m = 1; end
            2'b01: if (we_ok) begin
                addr_m = wa_m;
                wd_m = pl;
                mem_m[wa_m] = pl;
`ifdef SPI_RAM_AUTO_INC_EN
                wa_m = wa_m + 8'd1;
`endif
            end
            2'b10: begin ra_m = pl; rv_m = 1; end
            default: if (re_ok) begin
                addr_m = ra_m;
                rd_exp = mem_m[ra_m];
`ifdef SPI_RAM_AUTO_INC_EN
                ra_m = ra_m + 8'd1;
`endif
            end
        endcase

        @(negedge CLK);
        rx_data  = w;
        rx_valid = 1'b1;
        for (int k = 0; k < NOBS; k++) begin
            @(negedge CLK);
            if (has_extra && k == 2) err_m = 1;
            for (int g = 0; g < 3; g++) begin
                lat    = g + 1;
                exp_tv = re_ok && (k >= 1 + lat) && !(ssp != 0 && ssp <= k);
                check($sformatf("%03h L%0d k%0d ram_we", w, lat, k), ram_we_w[g], (we_ok && k == 0) ? 1 : 0);
                check($sformatf("%03h L%0d k%0d ram_re", w, lat, k), ram_re_w[g], (re_ok && k == 0) ? 1 : 0);
                check($sformatf("%03h L%0d k%0d busy", w, lat, k), busy_w[g],
                      ((we_ok && k == 0) || (re_ok && k <= lat)) ? 1 : 0);
                check($sformatf("%03h L%0d k%0d tx_valid", w, lat, k), tx_valid_w[g], exp_tv);
                check($sformatf("%03h L%0d k%0d cmd_err", w, lat, k), cmd_err_w[g], err_m);
                check($sformatf("%03h L%0d k%0d ram_addr", w, lat, k), ram_addr_w[g], addr_m);
                check($sformatf("%03h L%0d k%0d ram_wdata", w, lat, k), ram_wdata_w[g], wd_m);
                if (exp_tv) check($sformatf("%03h L%0d k%0d tx_data", w, lat, k), tx_data_w[g], rd_exp);
                if (k == NOBS - 1) begin
                    tv_m[g] = exp_tv;
                    if (exp_tv) td_m[g] = rd_exp;
                end
            end
            if (k + 1 >= hold) rx_valid = 1'b0;
            if (has_extra && k == 1) begin
                rx_data  = extra;
                rx_valid = 1'b1;
            end
            if (has_extra && k == 2) rx_valid = 1'b0;
            ss_n = (ssp != 0 && k == ssp - 1) ? 1'b1 : 1'b0;
        end
    endtask

    initial begin
        logic [1:0] c;
        logic [7:0] pl;
        int         ssp;

        for (int i = 0; i < 256; i++) mem_m[i] = 8'(i * 7 + 3);
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        ss_n     = 1'b0;
        reset_model();
        repeat (2) @(negedge CLK);
        check_reset("reset");
        rst = 1'b0;

        // basic write then read-back on every latency
        issue(10'h012, 1, 0, 10'h0, 0);
        issue(10'h1A5, 1, 0, 10'h0, 0);
        issue(10'h212, 1, 0, 10'h0, 0);
        issue(10'h300, 1, 0, 10'h0, 0);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("hold L%0d tx_valid", g + 1), tx_valid_w[g], tv_m[g]);
            check($sformatf("hold L%0d tx_data", g + 1), tx_data_w[g], 8'hA5);
        end
        ss_n = 1'b1;
        @(negedge CLK);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("ss release L%0d tx_valid", g + 1), tx_valid_w[g], 0);
            tv_m[g] = 0;
        end
        ss_n = 1'b0;

        // held rx_valid: one write only; wrap of write address under auto-increment
        issue(10'h0FF, 1, 0, 10'h0, 0);
        issue(10'h1FF, 3, 0, 10'h0, 0);
        issue(10'h1C3, 1, 0, 10'h0, 0);
        issue(10'h2FF, 1, 0, 10'h0, 0);
        issue(10'h300, 1, 0, 10'h0, 0);
        issue(10'h300, 1, 0, 10'h0, 0);

        // deselect pulse inside the read window discards the result
        issue(10'h212, 1, 0, 10'h0, 0);
        issue(10'h300, 1, 2, 10'h0, 0);
        // command arriving while busy is dropped and flags an error
        issue(10'h300, 1, 0, 10'h077, 1);
        issue(10'h1EE, 1, 0, 10'h0, 0);

        // asynchronous reset in the middle of RD_WAIT
        issue(10'h205, 1, 0, 10'h0, 0);
        @(negedge CLK);
        rx_data  = 10'h300;
        rx_valid = 1'b1;
        @(negedge CLK);
        rx_valid = 1'b0;
        @(negedge CLK);
        check("pre-rst busy", busy_w, 3'b111);
        #2 rst = 1'b1;
        #1 check_reset("async rst");
        reset_model();
        @(negedge CLK);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            check($sformatf("post-rst k%0d ram_we", k), ram_we_w, 3'b000);
            check($sformatf("post-rst k%0d ram_re", k), ram_re_w, 3'b000);
            check($sformatf("post-rst k%0d busy", k), busy_w, 3'b000);
        end

        // data command without address: sticky error through later legal traffic
        issue(10'h155, 1, 0, 10'h0, 0);
        issue(10'h010, 1, 0, 10'h0, 0);
        issue(10'h122, 1, 0, 10'h0, 0);
        issue(10'h210, 1, 0, 10'h0, 0);
        issue(10'h300, 1, 0, 10'h0, 0);

        for (int n = 0; n < 60; n++) begin
            c   = 2'($urandom_range(0, 3));
            pl  = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) pl = pl | 8'hF0;
            ssp = (c == 2'b11 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            issue({c, pl}, int'($urandom_range(1, 3)), ssp, 10'h0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
